execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
// - RV32I execute stage with the integer register file x0..x31, which is exported on o_X.
// - Executes one instruction, presented on i_inst, per issue.
// - Talks to a byte-wide memory port: multi-byte loads/stores take 1 beat (cycle) per byte, big-endian.
// - Reports control-flow redirects to fetch through o_pc_change/o_new_pc.
// PARAMETERS
// - None. Widths come from common.svh: WORD_WIDTH=32, DATA_WIDTH=8, INST_WIDTH=32.
// PORTS
// i_clk        in   1   clock; all state updates on the rising edge
// i_rst        in   1   reset, asynchronous, active-high
// i_inst       in   32  current instruction; held stable until it retires
// i_mem_data   in   8   read data for o_mem_addr (combinational memory)
// o_mem_addr   out  32  byte address of the current beat
// o_mem_write  out  1   write strobe for the current beat
// o_mem_data   out  8   write data byte
// i_pc         in   32  PC of i_inst
// o_pc_change  out  1   redirect request, valid this cycle
// o_new_pc     out  32  redirect target
// o_ready      out  1   1 = no multi-beat op in flight; the next edge begins a new instruction
// o_X          out  32x[0:31]  register file contents
// BEHAVIOUR
// - Reset: all x* = 0, beat counter = 0, o_ready = 1, o_mem_write = 0, o_mem_data = 0, o_pc_change = 0.
// - x0 reads as 0; writes to x0 are discarded.
// - Single-cycle ops (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH) write rd on the next edge; o_ready stays 1.
// - I-immediates are sign-extended; LUI gives rd = imm20<<12.
// - JAL/JALR/taken branch: combinational o_pc_change = 1.
//   - o_new_pc = i_pc+imm for JAL/branch; (rs1+imm)&~1 for JALR.
//   - rd = i_pc+4.
//   - When no redirect, o_pc_change = 0 and o_new_pc = i_pc+4.
// - Memory ops: N = 1/2/4 beats for B/H/W, beat counter k = 0..N-1.
//   - o_mem_addr is combinational: rs1+imm at k = 0.
//   - For k > 0, use the base latched at beat 0, plus k. This keeps addresses stable when rd == rs1.
//   - With no memory op, o_mem_addr = 0.
// - Load beat k, at the edge:
//   - k = 0: rd <= byte << 8*(N-1). Older rd bits are cleared.
//   - k > 0: rd |= byte << 8*(N-1-k).
//   - Last beat: result sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
// - Store beat k: o_mem_write = 1, o_mem_data = rs2 byte (N-1-k), with the MSB byte first.
// - o_ready: 0 after each non-final beat edge; 1 after the final beat edge. An N=1 op never drops it.
// - The issuer changes i_inst only after an edge where o_ready = 1. Holding it re-executes it.
// - Unknown opcodes act as NOPs.
// - Reset mid-operation aborts the op; state returns to reset values.
// TESTING
// - Reg write: LUI x2,0xFFFFF; ADDI x2,x0,0xFFF -> X[2] = 0xFFFFFFFF.
// - Reg write: ADDI x1,x0,-1366 -> X[1] = -1366. Then ADDI x1,x0,10 -> 10; o_ready = 1 throughout.
// - Mem model used below: bytes 0..5 = AA,BB,CC,DD,44,55.
// - LB x8,2(x0):
//   - o_mem_addr = 2 at #1 after issue.
//   - Next edge: X[8] = 0xFFFFFFCC, o_ready = 1.
//   - LB at address 4 -> 0x44.
// - LH x2,0(x0):
//   - Edge 1: X[2] = 0xAA00, o_ready = 0, o_mem_addr = 1.
//   - Edge 2: X[2] = 0xFFFFAABB, o_ready = 1.
//   - LHU at address 3 -> 0xDD00, then 0xDD44.
// - LW x15,1(x0): X[15] = BB000000, BBCC0000, BBCCDD00, BBCCDD44.
//   - o_mem_addr = 2,3,4 after edges 1-3; o_ready = 0 until edge 4.
// - SW/SH/SB with x6 = 0x11223344 at address 8:
//   - SW: o_mem_write = 1 each beat; addresses 8..11 carry 11,22,33,44.
//   - SH: addresses 8..9 carry 33,44.
//   - SB: address 8 carries 44.
// - Control flow: JAL x1,+8 at i_pc=0x100 -> o_pc_change = 1, o_new_pc = 0x108, X[1] = 0x104.
//   - BEQ with unequal operands -> o_pc_change = 0.

Source files
------------

// File: rtl/execute.sv
// RV32I execute stage: register file, ALU, branch resolution and a byte-serial
// big-endian load/store engine that spends one beat per byte.
module execute (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_inst,
    input  logic [7:0]  i_mem_data,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_write,
    output logic [7:0]  o_mem_data,
    input  logic [31:0] i_pc,
    output logic        o_pc_change,
    output logic [31:0] o_new_pc,
    output logic        o_ready,
    output logic [31:0] o_X [0:31]
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [31:0] regs_q [0:31];
    logic [1:0]  beat_q, beat_d;
    logic [31:0] base_q, base_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, rd_val, pc_plus4;

    assign opcode = i_inst[6:0];
    assign rd     = i_inst[11:7];
    assign funct3 = i_inst[14:12];
    assign rs1    = i_inst[19:15];
    assign rs2    = i_inst[24:20];

    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u = {i_inst[31:12], 12'h000};
    assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // regs_q[0] is reset to zero and never written, so x0 reads as 0.
    assign rs1_val  = regs_q[rs1];
    assign rs2_val  = regs_q[rs2];
    assign rd_val   = regs_q[rd];
    assign pc_plus4 = i_pc + 32'd4;

    // ALU shared by OP and OP_IMM; SUB only exists in register form.
    logic [31:0] alu_b, alu_res;
    logic [4:0]  shamt;
    assign alu_b = (opcode == OP_R) ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = ((opcode == OP_R) && i_inst[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = i_inst[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_taken = rs1_val < rs2_val;
            3'b111:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // Memory op decode: beat k moves byte (N-1-k), i.e. MSB first.
    logic        load_op, store_op, mem_op, last_beat;
    logic [1:0]  n_m1, byte_sel;
    logic [4:0]  shift;
    logic [31:0] ld_acc, ld_val, st_word;

    assign load_op  = (opcode == OP_LOAD) && (funct3 != 3'b011) && (funct3 != 3'b110)
                      && (funct3 != 3'b111);
    assign store_op = (opcode == OP_STORE) && (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    assign mem_op   = load_op || store_op;

    always_comb begin
        n_m1 = 2'd3;
        case (funct3[1:0])
            2'b00:   n_m1 = 2'd0;
            2'b01:   n_m1 = 2'd1;
            default: n_m1 = 2'd3;
        endcase
    end

    assign last_beat = (beat_q == n_m1);
    assign byte_sel  = n_m1 - beat_q;
    assign shift     = {byte_sel, 3'b000};
    assign ld_acc    = ((beat_q == 2'd0) ? 32'd0 : rd_val) | ({24'd0, i_mem_data} << shift);
    assign st_word   = rs2_val >> shift;

    always_comb begin
        ld_val = ld_acc;
        if (last_beat) begin
            case (funct3)
                3'b000:  ld_val = {{24{ld_acc[7]}}, ld_acc[7:0]};
                3'b001:  ld_val = {{16{ld_acc[15]}}, ld_acc[15:0]};
                3'b100:  ld_val = {24'd0, ld_acc[7:0]};
                3'b101:  ld_val = {16'd0, ld_acc[15:0]};
                default: ld_val = ld_acc;
            endcase
        end
    end

    logic        wb_en, pc_change;
    logic [31:0] wb_data, new_pc, mem_addr;

    always_comb begin
        wb_en     = 1'b0;
        wb_data   = '0;
        pc_change = 1'b0;
        new_pc    = pc_plus4;
        mem_addr  = '0;
        beat_d    = '0;
        base_d    = base_q;
        case (opcode)
            OP_R, OP_IMM: begin
                wb_en   = 1'b1;
                wb_data = alu_res;
            end
            OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = i_pc + imm_u;
            end
            OP_JAL: begin
                wb_en     = 1'b1;
                wb_data   = pc_plus4;
                pc_change = 1'b1;
                new_pc    = i_pc + imm_j;
            end
            OP_JALR: begin
                wb_en     = 1'b1;
                wb_data   = pc_plus4;
                pc_change = 1'b1;
                new_pc    = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                if (br_taken) begin
                    pc_change = 1'b1;
                    new_pc    = i_pc + imm_b;
                end
            end
            default: ;
        endcase

        // Later beats use the latched base so a load into rs1 cannot move the address.
        if (mem_op) begin
            if (beat_q == 2'd0) begin
                mem_addr = rs1_val + (store_op ? imm_s : imm_i);
                base_d   = mem_addr;
            end else begin
                mem_addr = base_q + {30'd0, beat_q};
            end
            beat_d = last_beat ? 2'd0 : beat_q + 2'd1;
            if (load_op) begin
                wb_en   = 1'b1;
                wb_data = ld_val;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            beat_q <= '0;
            base_q <= '0;
        end else begin
            beat_q <= beat_d;
            base_q <= base_d;
            if (wb_en && (rd != 5'd0)) regs_q[rd] <= wb_data;
        end
    end

    assign o_X         = regs_q;
    assign o_ready     = (beat_q == 2'd0);
    assign o_mem_addr  = mem_addr;
    assign o_mem_write = store_op && !i_rst;
    assign o_mem_data  = o_mem_write ? st_word[7:0] : 8'h00;
    assign o_pc_change = pc_change && !i_rst;
    assign o_new_pc    = new_pc;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: instruction encoders, a 16-byte memory
// model and a store-beat scoreboard fed from an expected queue.
module tb_execute;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [7:0]  mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [31:0] pc;
  logic        pc_change;
  logic [31:0] new_pc;
  logic        ready;
  logic [31:0] x_o [0:31];

  logic [7:0]  mem [0:15];
  logic [39:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  localparam logic [31:0] NOP = 32'h0000_0013;

  execute dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_inst      (inst),
    .i_mem_data  (mem_rdata),
    .o_mem_addr  (mem_addr),
    .o_mem_write (mem_write),
    .o_mem_data  (mem_wdata),
    .i_pc        (pc),
    .o_pc_change (pc_change),
    .o_new_pc    (new_pc),
    .o_ready     (ready),
    .o_X         (x_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // memory model: combinational read, write on the edge, preset under reset
  assign mem_rdata = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hAA; mem[1] <= 8'hBB; mem[2] <= 8'hCC;
      mem[3] <= 8'hDD; mem[4] <= 8'h44; mem[5] <= 8'h55;
    end else if (mem_write && mem_addr < 32'd16) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every store beat must match the head of exp_q ({addr, data})
  always @(negedge clk) begin
    if (mem_write) begin
      if (exp_q.size() == 0) begin
        check("store_unexpected", {mem_addr[23:0], mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("store_addr", mem_addr, e[39:8]);
        check("store_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
      end
    end
  end

  // encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // driver tasks: callers sit #1 after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exec1(input logic [31:0] i);
    inst = i;
    step();
  endtask

  initial begin
    logic [11:0] r;
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    inst = NOP;
    pc   = 32'h0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_data", {24'd0, mem_wdata}, 32'd0);
    check("rst_pc_change", {31'd0, pc_change}, 32'd0);
    check("rst_x5", x_o[5], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // register writes
    exec1({20'hFFFFF, 5'd2, 7'b0110111});
    check("lui_x2", x_o[2], 32'hFFFF_F000);
    exec1(enc_i(12'hFFF, 5'd0, 3'b000, 5'd2, 7'b0010011));
    check("addi_x2", x_o[2], 32'hFFFF_FFFF);
    exec1(enc_i(12'hAAA, 5'd0, 3'b000, 5'd1, 7'b0010011));
    check("addi_neg_x1", x_o[1], 32'hFFFF_FAAA);
    check("addi_ready", {31'd0, ready}, 32'd1);
    exec1(enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011));
    check("addi_x1_10", x_o[1], 32'd10);
    check("addi_ready2", {31'd0, ready}, 32'd1);

    // ALU ops with x1 = 10, x2 = -1
    exec1(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
    check("add_x3", x_o[3], 32'd9);
    exec1(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));
    check("sub_x4", x_o[4], 32'd11);
    exec1(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5));
    check("slt_x5", x_o[5], 32'd1);
    exec1(enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6));
    check("sltu_x6", x_o[6], 32'd0);
    exec1(enc_i(12'hFF0, 5'd0, 3'b000, 5'd7, 7'b0010011));
    exec1(enc_i(12'h402, 5'd7, 3'b101, 5'd7, 7'b0010011));
    check("srai_x7", x_o[7], 32'hFFFF_FFFC);
    exec1(enc_i(12'h002, 5'd7, 3'b101, 5'd7, 7'b0010011));
    check("srli_x7", x_o[7], 32'h3FFF_FFFF);
    exec1(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));
    check("x0_stays_zero", x_o[0], 32'd0);
    r = 12'($urandom_range(0, 2047));
    exec1(enc_i(r, 5'd0, 3'b000, 5'd11, 7'b0010011));
    check("addi_rand_x11", x_o[11], {20'd0, r});
    exec1(32'hFFFF_FFFF);
    check("unknown_nop_x1", x_o[1], 32'd10);
    check("unknown_ready", {31'd0, ready}, 32'd1);

    // byte loads
    inst = enc_i(12'd2, 5'd0, 3'b000, 5'd8, 7'b0000011);
    #1;
    check("lb_addr", mem_addr, 32'd2);
    step();
    check("lb_x8", x_o[8], 32'hFFFF_FFCC);
    check("lb_ready", {31'd0, ready}, 32'd1);
    exec1(enc_i(12'd4, 5'd0, 3'b000, 5'd9, 7'b0000011));
    check("lb_x9", x_o[9], 32'h0000_0044);

    // halfword loads
    exec1(enc_i(12'd0, 5'd0, 3'b001, 5'd2, 7'b0000011));
    check("lh_e1_x2", x_o[2], 32'h0000_AA00);
    check("lh_e1_ready", {31'd0, ready}, 32'd0);
    check("lh_e1_addr", mem_addr, 32'd1);
    step();
    check("lh_e2_x2", x_o[2], 32'hFFFF_AABB);
    check("lh_e2_ready", {31'd0, ready}, 32'd1);
    exec1(enc_i(12'd3, 5'd0, 3'b101, 5'd3, 7'b0000011));
    check("lhu_e1_x3", x_o[3], 32'h0000_DD00);
    step();
    check("lhu_e2_x3", x_o[3], 32'h0000_DD44);

    // word loads
    exec1(enc_i(12'd1, 5'd0, 3'b010, 5'd15, 7'b0000011));
    check("lw_e1_x15", x_o[15], 32'hBB00_0000);
    check("lw_e1_addr", mem_addr, 32'd2);
    check("lw_e1_ready", {31'd0, ready}, 32'd0);
    step();
    check("lw_e2_x15", x_o[15], 32'hBBCC_0000);
    check("lw_e2_addr", mem_addr, 32'd3);
    step();
    check("lw_e3_x15", x_o[15], 32'hBBCC_DD00);
    check("lw_e3_addr", mem_addr, 32'd4);
    check("lw_e3_ready", {31'd0, ready}, 32'd0);
    step();
    check("lw_e4_x15", x_o[15], 32'hBBCC_DD44);
    check("lw_e4_ready", {31'd0, ready}, 32'd1);

    // rd == rs1: later beats must keep the original base
    exec1(enc_i(12'd1, 5'd0, 3'b000, 5'd16, 7'b0010011));
    exec1(enc_i(12'd0, 5'd16, 3'b010, 5'd16, 7'b0000011));
    repeat (3) step();
    check("lw_rd_eq_rs1", x_o[16], 32'hBBCC_DD44);

    // stores with x6 = 0x11223344 at address 8
    exec1({20'h11223, 5'd6, 7'b0110111});
    exec1(enc_i(12'h344, 5'd6, 3'b000, 5'd6, 7'b0010011));
    check("x6_value", x_o[6], 32'h1122_3344);
    exp_q.push_back({32'd8, 8'h11});
    exp_q.push_back({32'd9, 8'h22});
    exp_q.push_back({32'd10, 8'h33});
    exp_q.push_back({32'd11, 8'h44});
    exec1(enc_s(12'd8, 5'd6, 5'd0, 3'b010));
    check("sw_e1_ready", {31'd0, ready}, 32'd0);
    repeat (3) step();
    check("sw_ready", {31'd0, ready}, 32'd1);
    check("sw_mem8", {24'd0, mem[8]}, 32'h11);
    check("sw_mem11", {24'd0, mem[11]}, 32'h44);
    exp_q.push_back({32'd8, 8'h33});
    exp_q.push_back({32'd9, 8'h44});
    exec1(enc_s(12'd8, 5'd6, 5'd0, 3'b001));
    step();
    check("sh_mem8", {24'd0, mem[8]}, 32'h33);
    check("sh_mem10", {24'd0, mem[10]}, 32'h33);
    exp_q.push_back({32'd8, 8'h44});
    exec1(enc_s(12'd8, 5'd6, 5'd0, 3'b000));
    check("sb_mem8", {24'd0, mem[8]}, 32'h44);
    check("sb_ready", {31'd0, ready}, 32'd1);
    inst = NOP;
    #1;
    check("nop_mem_addr", mem_addr, 32'd0);
    check("nop_mem_write", {31'd0, mem_write}, 32'd0);

    // control flow at pc 0x100
    pc   = 32'h100;
    inst = enc_j(21'd8, 5'd1);
    #1;
    check("jal_change", {31'd0, pc_change}, 32'd1);
    check("jal_target", new_pc, 32'h108);
    step();
    check("jal_link", x_o[1], 32'h104);
    inst = enc_b(13'd16, 5'd2, 5'd1, 3'b000);
    #1;
    check("beq_ne_change", {31'd0, pc_change}, 32'd0);
    check("beq_ne_next", new_pc, 32'h104);
    inst = enc_b(13'h1FF0, 5'd2, 5'd1, 3'b001);
    #1;
    check("bne_change", {31'd0, pc_change}, 32'd1);
    check("bne_target", new_pc, 32'hF0);
    step();
    check("bne_no_wb_x1", x_o[1], 32'h104);
    inst = enc_i(12'd3, 5'd1, 3'b000, 5'd5, 7'b1100111);
    #1;
    check("jalr_change", {31'd0, pc_change}, 32'd1);
    check("jalr_target", new_pc, 32'h106);
    step();
    check("jalr_link", x_o[5], 32'h104);
    pc = 32'h200;
    exec1({20'h00001, 5'd12, 7'b0010111});
    check("auipc_x12", x_o[12], 32'h1200);

    // reset in the middle of a word load
    exec1(enc_i(12'd0, 5'd0, 3'b010, 5'd10, 7'b0000011));
    check("abort_e1_ready", {31'd0, ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_x10", x_o[10], 32'd0);
    check("abort_x15", x_o[15], 32'd0);
    inst = NOP;
    @(negedge clk) rst = 1'b0;
    step();
    check("post_abort_ready", {31'd0, ready}, 32'd1);

    check("store_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
